// File: rtl/exec_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: phase encodings and
// the opcodes the surrounding core decodes.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_KEY = 3'd4
  } seq_state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_ALUI   = 7'h13;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

endpackage

// File: rtl/exec_sequencer_key.sv
// Rising-edge detector for the operator confirm level. The registered copy
// runs continuously so a level already high before KEY never looks fresh.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_finish,
  output logic rise
);

  logic key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= 1'b0;
    else     key_q <= key_finish;
  end

  assign rise = key_finish & ~key_q;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/KEY sequencer gating PC, IR, register-file and
// data-memory writes; stalls on ecall until confirm or optional timeout.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int          TIMEOUT_W   = 24,
  parameter int unsigned KEY_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        keyin,
  input  logic        key_finish,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        key_wait,
  output logic        key_timeout,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  seq_state_e           state_q;
  seq_state_e           state_d;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [31:0]          instret_q;
  logic                 key_rise;
  logic                 timeout_hit;
  logic                 opcode_unused;

  // The decision is taken entirely from the decoder strobes; opcode is kept
  // on the port for debug visibility only.
  assign opcode_unused = ^opcode;

  key_edge u_key_edge (
    .clk        (clk),
    .rst        (rst),
    .key_finish (key_finish),
    .rise       (key_rise)
  );

  assign timeout_hit = (KEY_TIMEOUT != 0) &&
                       (wait_cnt == TIMEOUT_W'(KEY_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    key_wait    = 1'b0;
    key_timeout = 1'b0;
    case (state_q)
      ST_IF: begin
        if (run) state_d = ST_ID;
      end
      ST_ID: begin
        ir_we   = 1'b1;
        state_d = ST_EX;
      end
      ST_EX: begin
        if (keyin) begin
          state_d = ST_KEY;
        end else if (mem_read) begin
          dmem_re = 1'b1;
          state_d = ST_MEM;
        end else if (mem_write) begin
          dmem_we = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_IF;
        end else begin
          rf_we   = reg_write;
          pc_we   = 1'b1;
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_IF;
      end
      ST_KEY: begin
        key_wait = 1'b1;
        // A confirm edge beats a coincident timeout so the typed value lands.
        if (key_rise) begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_IF;
        end else if (timeout_hit) begin
          pc_we       = 1'b1;
          key_timeout = 1'b1;
          state_d     = ST_IF;
        end
      end
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q == ST_EX && state_d == ST_KEY) begin
      wait_cnt <= '0;
    end else if (state_q == ST_KEY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: one instance without timeout, one with
// an 8-cycle KEY timeout, both fed from the same stimulus.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, mem_read, mem_write, reg_write, keyin, key_finish;
  logic [6:0]  opcode;

  logic        a_ir_we, a_pc_we, a_rf_we, a_dmem_re, a_dmem_we, a_key_wait, a_key_timeout;
  logic [31:0] a_instret;
  logic [2:0]  a_state;
  logic        b_ir_we, b_pc_we, b_rf_we, b_dmem_re, b_dmem_we, b_key_wait, b_key_timeout;
  logic [31:0] b_instret;
  logic [2:0]  b_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.TIMEOUT_W(24), .KEY_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .keyin(keyin), .key_finish(key_finish),
    .ir_we(a_ir_we), .pc_we(a_pc_we), .rf_we(a_rf_we),
    .dmem_re(a_dmem_re), .dmem_we(a_dmem_we),
    .key_wait(a_key_wait), .key_timeout(a_key_timeout),
    .instret(a_instret), .state(a_state)
  );

  exec_sequencer #(.TIMEOUT_W(24), .KEY_TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .keyin(keyin), .key_finish(key_finish),
    .ir_we(b_ir_we), .pc_we(b_pc_we), .rf_we(b_rf_we),
    .dmem_re(b_dmem_re), .dmem_we(b_dmem_we),
    .key_wait(b_key_wait), .key_timeout(b_key_timeout),
    .instret(b_instret), .state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and park on the falling edge, away from the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 7'h00;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    keyin = 1'b0; key_finish = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_state", a_state, 0);
    chk("rst_ir_we", a_ir_we, 0);
    chk("rst_pc_we", a_pc_we, 0);
    chk("rst_rf_we", a_rf_we, 0);
    chk("rst_dmem",  {a_dmem_re, a_dmem_we}, 0);
    chk("rst_keyout", {a_key_wait, a_key_timeout}, 0);
    chk("rst_instret", a_instret, 0);

    // addi: IF, ID, EX
    rst = 1'b0; run = 1'b1; opcode = 7'h13; reg_write = 1'b1;
    #1;
    chk("addi_c1_state", a_state, 0);
    step();
    chk("addi_c2_ir_we", a_ir_we, 1);
    chk("addi_c2_state", a_state, 1);
    step();
    chk("addi_c3_rf_pc", {a_rf_we, a_pc_we}, 2'b11);
    chk("addi_c3_ir_we", a_ir_we, 0);
    step();
    chk("addi_instret", a_instret, 1);
    chk("addi_back_if", a_state, 0);

    // load: IF, ID, EX, MEM
    opcode = 7'h03; mem_read = 1'b1; reg_write = 1'b1;
    step();
    chk("ld_id", a_state, 1);
    step();
    chk("ld_ex_state", a_state, 2);
    chk("ld_ex_strobes", {a_dmem_re, a_dmem_we, a_rf_we, a_pc_we}, 4'b1000);
    step();
    chk("ld_mem_state", a_state, 3);
    chk("ld_mem_strobes", {a_dmem_re, a_dmem_we, a_rf_we, a_pc_we}, 4'b0011);
    step();
    chk("ld_done", a_state, 0);
    chk("ld_instret", a_instret, 2);

    // store: dmem_we with pc_we, no register write
    opcode = 7'h23; mem_read = 1'b0; mem_write = 1'b1; reg_write = 1'b0;
    step();
    step();
    chk("st_ex_strobes", {a_dmem_re, a_dmem_we, a_rf_we, a_pc_we}, 4'b0101);
    step();
    chk("st_instret", a_instret, 3);

    // ecall with confirm already high on entry
    opcode = 7'h73; mem_write = 1'b0; keyin = 1'b1; reg_write = 1'b1; key_finish = 1'b1;
    step();
    step();
    chk("ec_ex_state", a_state, 2);
    chk("ec_ex_strobes", {a_dmem_re, a_dmem_we, a_rf_we, a_pc_we}, 4'b0000);
    step();
    chk("ec_key_state", a_state, 4);
    chk("ec_key_wait", a_key_wait, 1);
    chk("ec_level_ignored", a_pc_we, 0);
    for (int k = 2; k <= 9; k++) begin
      step();
      if (k == 3) begin
        key_finish = 1'b0;
        #1;
      end
      chk("ec_hold", {a_state, a_pc_we, a_key_timeout}, {3'd4, 1'b0, 1'b0});
    end
    step();
    key_finish = 1'b1;
    #1;
    chk("ec_edge_commit", {a_rf_we, a_pc_we, a_key_wait}, 3'b111);
    step();
    chk("ec_instret", a_instret, 4);
    chk("ec_exit", {a_state, a_key_wait}, 4'b0000);

    // run dropped during EX: instruction retires, FSM parks in IF
    keyin = 1'b0; opcode = 7'h13; reg_write = 1'b1;
    step();
    step();
    run = 1'b0;
    #1;
    chk("run_ex_pc_we", a_pc_we, 1);
    step();
    chk("run_instret", a_instret, 5);
    chk("run_park1", a_state, 0);
    step();
    chk("run_park2", {a_state, a_ir_we}, 4'b0000);
    run = 1'b1;
    step();
    chk("run_resume_id", {a_state, a_ir_we}, {3'd1, 1'b1});
    step();
    step();
    chk("run_instret2", a_instret, 6);

    // reset mid-KEY
    keyin = 1'b1; key_finish = 1'b0;
    step();
    step();
    step();
    chk("rk_in_key", a_state, 4);
    step();
    rst = 1'b1;
    #1;
    chk("rk_async", {a_state, a_key_wait, a_pc_we}, 5'b00000);
    chk("rk_instret", a_instret, 0);
    step();
    rst = 1'b0; keyin = 1'b0; mem_read = 1'b1;
    #1;
    chk("rk_release", a_state, 0);

    // reset mid-MEM: no partial commit
    step();
    step();
    chk("rm_ex_re", a_dmem_re, 1);
    step();
    chk("rm_mem_rf", a_rf_we, 1);
    rst = 1'b1;
    #1;
    chk("rm_async", {a_state, a_rf_we, a_pc_we}, 5'b00000);
    step();
    rst = 1'b0;
    #1;
    chk("rm_no_commit", a_instret, 0);

    // timeout instance: keyin beats mem_read, then 8 KEY cycles
    keyin = 1'b1; mem_read = 1'b1; key_finish = 1'b0;
    step();
    step();
    chk("to_ex_prio", {b_state, b_dmem_re}, {3'd2, 1'b0});
    step();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      if (k < 8)
        chk("to_wait", {b_key_wait, b_key_timeout, b_pc_we}, 3'b100);
      else
        chk("to_fire", {b_key_wait, b_key_timeout, b_pc_we, b_rf_we}, 4'b1110);
    end
    step();
    chk("to_instret", b_instret, 1);
    chk("to_exit", b_state, 0);
    chk("to_a_still_key", a_state, 4);

    // edge coinciding with the timeout cycle wins
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    step();
    step();
    step();
    for (int k = 2; k <= 8; k++) step();
    key_finish = 1'b1;
    #1;
    chk("tie_b", {b_rf_we, b_pc_we, b_key_timeout}, 3'b110);
    chk("tie_a", {a_rf_we, a_pc_we}, 2'b11);
    run = 1'b0;
    step();
    chk("tie_b_instret", b_instret, 1);
    chk("tie_a_instret", a_instret, 1);

    // instret wrap
    keyin = 1'b0; mem_read = 1'b0; reg_write = 1'b1; opcode = 7'h13;
    step();
    chk("wrap_parked", a_state, 0);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    run = 1'b1;
    step();
    step();
    chk("wrap_ex_pc_we", a_pc_we, 1);
    step();
    chk("wrap_instret", a_instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
